// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes and EX forwarding selects
// for a 5-stage RISC-V core. Tracks destination registers in flight through EX/MEM/WB.
module hazard_scheduler #(
    parameter bit          FWD_EN      = 1'b1,
    parameter int unsigned FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_wb,
    input  logic        id_mem_rd,
    input  logic        ex_redirect,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W     = 16;
    localparam bit          KILL_IDEX = (FLUSH_SLOTS >= 2);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    state_t             r_state;
    logic [1:0]         r_kill_left;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               r_ex_valid, r_ex_wb, r_ex_mem_rd, r_ex_use1, r_ex_use2;
    logic [REG_W-1:0]   r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic               r_mem_valid, r_mem_wb, r_mem_mem_rd;
    logic [REG_W-1:0]   r_mem_rd;
    logic               r_wb_valid, r_wb_wb;
    logic [REG_W-1:0]   r_wb_rd;

    logic               w_id_live, w_hit_ex, w_hit_mem, w_hit_wb;
    logic               w_hazard, w_hold, w_kill, w_bubble;
    logic [1:0]         w_fwd_a, w_fwd_b;

    // A slot only produces when valid, writing back, and not targeting x0.
    function automatic logic hits(input logic v, input logic wb, input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] rs, input logic use_rs);
        return v && wb && (rd != '0) && (rd == rs) && use_rs;
    endfunction

    always_comb begin
        // The ID slot during FLUSH holds the zeroed IF/ID contents and is ignored.
        w_id_live = id_valid && (r_state != S_FLUSH);
        w_hit_ex  = hits(r_ex_valid, r_ex_wb, r_ex_rd, id_rs1, id_use_rs1) ||
                    hits(r_ex_valid, r_ex_wb, r_ex_rd, id_rs2, id_use_rs2);
        w_hit_mem = hits(r_mem_valid, r_mem_wb, r_mem_rd, id_rs1, id_use_rs1) ||
                    hits(r_mem_valid, r_mem_wb, r_mem_rd, id_rs2, id_use_rs2);
        w_hit_wb  = hits(r_wb_valid, r_wb_wb, r_wb_rd, id_rs1, id_use_rs1) ||
                    hits(r_wb_valid, r_wb_wb, r_wb_rd, id_rs2, id_use_rs2);
        if (FWD_EN)
            w_hazard = w_id_live && w_hit_ex && r_ex_mem_rd && (r_state != S_STALL);
        else
            w_hazard = w_id_live && (w_hit_ex || w_hit_mem || w_hit_wb);
        w_kill   = ex_redirect && !rst;
        w_hold   = w_hazard && !w_kill && !rst;
        w_bubble = w_hold || (w_kill && KILL_IDEX);
    end

    // MEM beats WB; a load still in MEM has no data to forward yet.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (FWD_EN && r_ex_valid && !rst) begin
            if (hits(r_mem_valid, r_mem_wb, r_mem_rd, r_ex_rs1, r_ex_use1) && !r_mem_mem_rd)
                w_fwd_a = 2'b01;
            else if (hits(r_wb_valid, r_wb_wb, r_wb_rd, r_ex_rs1, r_ex_use1))
                w_fwd_a = 2'b10;
            if (hits(r_mem_valid, r_mem_wb, r_mem_rd, r_ex_rs2, r_ex_use2) && !r_mem_mem_rd)
                w_fwd_b = 2'b01;
            else if (hits(r_wb_valid, r_wb_wb, r_wb_rd, r_ex_rs2, r_ex_use2))
                w_fwd_b = 2'b10;
        end
    end

    always_comb begin
        pc_write    = !w_hold;
        ifid_write  = !w_hold;
        ifid_flush  = w_kill;
        idex_bubble = w_bubble;
        fwd_a       = w_fwd_a;
        fwd_b       = w_fwd_b;
        stall_cnt   = r_stall_cnt;
    end

    // Sequencing FSM plus the stage tracking shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_kill_left  <= 2'd0;
            r_stall_cnt  <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_wb      <= 1'b0;
            r_ex_mem_rd  <= 1'b0;
            r_ex_use1    <= 1'b0;
            r_ex_use2    <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_wb     <= 1'b0;
            r_mem_mem_rd <= 1'b0;
            r_mem_rd     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_wb      <= 1'b0;
            r_wb_rd      <= '0;
        end else begin
            r_wb_valid   <= r_mem_valid;
            r_wb_wb      <= r_mem_wb;
            r_wb_rd      <= r_mem_rd;
            r_mem_valid  <= r_ex_valid;
            r_mem_wb     <= r_ex_wb;
            r_mem_mem_rd <= r_ex_mem_rd;
            r_mem_rd     <= r_ex_rd;

            if (w_id_live && !w_bubble) begin
                r_ex_valid  <= 1'b1;
                r_ex_wb     <= id_wb;
                r_ex_mem_rd <= id_mem_rd;
                r_ex_use1   <= id_use_rs1;
                r_ex_use2   <= id_use_rs2;
                r_ex_rd     <= id_rd;
                r_ex_rs1    <= id_rs1;
                r_ex_rs2    <= id_rs2;
            end else begin
                r_ex_valid  <= 1'b0;
                r_ex_wb     <= 1'b0;
                r_ex_mem_rd <= 1'b0;
                r_ex_use1   <= 1'b0;
                r_ex_use2   <= 1'b0;
                r_ex_rd     <= '0;
                r_ex_rs1    <= '0;
                r_ex_rs2    <= '0;
            end

            if (w_hold && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);

            case (r_state)
                S_RUN, S_STALL: r_state <= w_hold ? S_STALL : S_RUN;
                S_FLUSH: begin
                    if (r_kill_left > 2'd1) begin
                        r_kill_left <= r_kill_left - 2'd1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            // A redirect overrides everything, including a pending flush.
            if (ex_redirect) begin
                if (KILL_IDEX) begin
                    r_state     <= S_FLUSH;
                    r_kill_left <= 2'(FLUSH_SLOTS - 1);
                end else begin
                    r_state     <= S_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a cycle table for the forwarding instance plus
// hand sequences for reset, repeated redirect and the no-forwarding / single-slot variant.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_wb, id_mem_rd, ex_redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        nf_pc_write, nf_ifid_write, nf_ifid_flush, nf_idex_bubble;
    logic [1:0]  nf_fwd_a, nf_fwd_b;
    logic [15:0] nf_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.FWD_EN(1'b1), .FLUSH_SLOTS(2)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wb(id_wb),
        .id_mem_rd(id_mem_rd), .ex_redirect(ex_redirect), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    hazard_scheduler #(.FWD_EN(1'b0), .FLUSH_SLOTS(1)) u_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wb(id_wb),
        .id_mem_rd(id_mem_rd), .ex_redirect(ex_redirect), .pc_write(nf_pc_write),
        .ifid_write(nf_ifid_write), .ifid_flush(nf_ifid_flush), .idex_bubble(nf_idex_bubble),
        .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .stall_cnt(nf_stall_cnt)
    );

    // Expected word: {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt}
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        wb, mrd, redir;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic wb, input logic mrd, input logic redir,
                                input logic [7:0] ctl, input logic [15:0] cnt);
        vec_t x;
        x.v = v; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.rd = rd; x.wb = wb; x.mrd = mrd; x.redir = redir;
        x.exp = {ctl, cnt};
        return x;
    endfunction

    function automatic vec_t nop(input logic [7:0] ctl, input logic [15:0] cnt);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, cnt);
    endfunction

    task automatic drive(input vec_t x);
        id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
        id_rd = x.rd; id_wb = x.wb; id_mem_rd = x.mrd; ex_redirect = x.redir;
    endtask

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] dut_word();
        return {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt};
    endfunction

    function automatic logic [23:0] nf_word();
        return {nf_pc_write, nf_ifid_write, nf_ifid_flush, nf_idex_bubble,
                nf_fwd_a, nf_fwd_b, nf_stall_cnt};
    endfunction

    localparam logic [7:0] RUN  = 8'hC0;   // pc/ifid write, nothing killed, no forward
    localparam logic [7:0] HOLD = 8'h10;   // ID held, bubble into EX
    localparam logic [7:0] KILL = 8'hF0;   // redirect with two kill slots

    initial begin
        // lw x5,0(x1); add x6,x5,x2 -> one stall, then WB forward on A
        vecs.push_back(mk(1, 5'd1,  5'd0,  1, 0, 5'd5,  1, 1, 0, RUN,   16'd0));
        vecs.push_back(mk(1, 5'd5,  5'd2,  1, 1, 5'd6,  1, 0, 0, HOLD,  16'd0));
        vecs.push_back(mk(1, 5'd5,  5'd2,  1, 1, 5'd6,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(nop(8'hC8, 16'd1));
        // add x5,x1,x2; sub x7,x5,x5 -> MEM forward on both
        vecs.push_back(mk(1, 5'd1,  5'd2,  1, 1, 5'd5,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(mk(1, 5'd5,  5'd5,  1, 1, 5'd7,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(nop(8'hC5, 16'd1));
        // add x5; nop; or x8,x5,x0 -> WB forward on A only
        vecs.push_back(mk(1, 5'd1,  5'd2,  1, 1, 5'd5,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(nop(RUN, 16'd1));
        vecs.push_back(mk(1, 5'd5,  5'd0,  1, 1, 5'd8,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(nop(8'hC8, 16'd1));
        // lw x0,0(x1); add x9,x0,x0 -> no stall, no forward
        vecs.push_back(mk(1, 5'd1,  5'd0,  1, 0, 5'd0,  1, 1, 0, RUN,   16'd1));
        vecs.push_back(mk(1, 5'd0,  5'd0,  1, 1, 5'd9,  1, 0, 0, RUN,   16'd1));
        vecs.push_back(nop(RUN, 16'd1));
        // load-use coinciding with redirect -> flush wins, no stall counted
        vecs.push_back(mk(1, 5'd1,  5'd0,  1, 0, 5'd5,  1, 1, 0, RUN,   16'd1));
        vecs.push_back(mk(1, 5'd5,  5'd2,  1, 1, 5'd6,  1, 0, 1, KILL,  16'd1));
        vecs.push_back(nop(RUN, 16'd1));
        // back in RUN: a fresh load-use stalls normally
        vecs.push_back(mk(1, 5'd1,  5'd0,  1, 0, 5'd11, 1, 1, 0, RUN,   16'd1));
        vecs.push_back(mk(1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 0, HOLD,  16'd1));
        vecs.push_back(mk(1, 5'd11, 5'd11, 1, 1, 5'd12, 1, 0, 0, RUN,   16'd2));
        vecs.push_back(nop(8'hCA, 16'd2));

        // Reset state, with a redirect and hazard-looking ID present
        rst = 1'b1;
        drive(mk(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 1, 1, RUN, 16'd0));
        #3;
        chk("reset_outputs", dut_word(), {RUN, 16'd0});
        chk("reset_outputs_nf", nf_word(), {RUN, 16'd0});
        @(negedge clk);
        drive(nop(RUN, 16'd0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk($sformatf("vec%0d", i), dut_word(), vecs[i].exp);
        end

        // Reset asserted in the middle of a stall cycle
        @(negedge clk);
        drive(mk(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, RUN, 16'd0));
        @(negedge clk);
        drive(mk(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0, RUN, 16'd0));
        #2;
        chk("stall_before_reset", dut_word(), {HOLD, 16'd2});
        #1;
        rst = 1'b1;
        ex_redirect = 1'b1;
        #1;
        chk("reset_mid_stall", dut_word(), {RUN, 16'd0});
        @(negedge clk);
        rst = 1'b0;
        ex_redirect = 1'b0;
        #2;
        chk("first_cycle_after_reset", dut_word(), {RUN, 16'd0});

        // Redirect during FLUSH restarts the kill
        @(negedge clk);
        drive(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, RUN, 16'd0));
        #2;
        chk("redirect_first", dut_word(), {KILL, 16'd0});
        @(negedge clk);
        #2;
        chk("redirect_in_flush", dut_word(), {KILL, 16'd0});
        @(negedge clk);
        ex_redirect = 1'b0;
        #2;
        chk("flush_done", dut_word(), {RUN, 16'd0});

        // No-forwarding instance: stall until the producer leaves WB; single kill slot
        rst = 1'b1;
        drive(nop(RUN, 16'd0));
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, RUN, 16'd0));
        #2;
        chk("nf_producer", nf_word(), {RUN, 16'd0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(mk(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0, 0, RUN, 16'd0));
            #2;
            chk($sformatf("nf_hold%0d", k), nf_word(), {HOLD, 16'(k)});
        end
        @(negedge clk);
        #2;
        chk("nf_release", nf_word(), {RUN, 16'd3});
        @(negedge clk);
        drive(nop(RUN, 16'd0));
        #2;
        chk("nf_no_forward", nf_word(), {RUN, 16'd3});
        @(negedge clk);
        ex_redirect = 1'b1;
        #2;
        chk("nf_redirect_one_slot", nf_word(), {8'hE0, 16'd3});
        @(negedge clk);
        ex_redirect = 1'b0;
        #2;
        chk("nf_after_redirect", nf_word(), {RUN, 16'd3});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
